// File: rtl/apu_package.sv
// Shared APU types for the FP divider issue path: request/response records and FSM state.
package apu_package;

    localparam int unsigned WAPUTAG      = 5;
    localparam int unsigned NDSFLAGS_DIV = 3;
    localparam int unsigned NUSFLAGS_DIV = 5;
    localparam int unsigned APU_FP_WIDTH = 32;

    typedef struct packed {
        logic [APU_FP_WIDTH-1:0] op_a;
        logic [APU_FP_WIDTH-1:0] op_b;
        logic [NDSFLAGS_DIV-1:0] rnd;
        logic [WAPUTAG-1:0]      tag;
    } div_req_t;

    typedef struct packed {
        logic [APU_FP_WIDTH-1:0] res;
        logic [NUSFLAGS_DIV-1:0] status;
        logic [WAPUTAG-1:0]      tag;
    } div_rsp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

endpackage

// File: rtl/fp_div_fifo.sv
// Small synchronous FIFO of an arbitrary packed type; power-of-two depth, reports full/empty/count.
module fp_div_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;

    // A push while full is only issued together with a pop; the head is read
    // out before the edge, so overwriting that slot is safe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);

endmodule

// File: rtl/fp_div_issue_ctrl.sv
// Issue controller for the shared sequential FP divider: buffers requests, issues one at a time
// against a response-slot credit, and captures every completion. FP_DIV_ISSUE_WDOG_EN adds a watchdog.
//
// state | meaning
// IDLE  | no divide in flight; may issue when a request, divider ready and credit line up
// BUSY  | one divide in flight; completion captured, may re-issue in the same cycle
module fp_div_issue_ctrl
    import apu_package::*;
#(
    parameter int unsigned FP_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH  = WAPUTAG,
    parameter int unsigned RND_WIDTH  = NDSFLAGS_DIV,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_DIV,
    parameter int unsigned REQ_DEPTH  = 2,
    parameter int unsigned RSP_DEPTH  = 2,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [FP_WIDTH-1:0]   req_op_a_i,
    input  logic [FP_WIDTH-1:0]   req_op_b_i,
    input  logic [RND_WIDTH-1:0]  req_rnd_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [FP_WIDTH-1:0]   resp_res_o,
    output logic [STAT_WIDTH-1:0] resp_status_o,
    output logic [TAG_WIDTH-1:0]  resp_tag_o,
    output logic                  div_en_o,
    output logic [FP_WIDTH-1:0]   div_op_a_o,
    output logic [FP_WIDTH-1:0]   div_op_b_o,
    output logic [RND_WIDTH-1:0]  div_rnd_o,
    output logic [TAG_WIDTH-1:0]  div_tag_o,
    input  logic                  div_ready_i,
    input  logic                  div_valid_i,
    input  logic [FP_WIDTH-1:0]   div_res_i,
    input  logic [STAT_WIDTH-1:0] div_status_i,
    input  logic [TAG_WIDTH-1:0]  div_tag_i,
    output logic                  err_o
);

    div_req_t req_wdata, req_head;
    div_rsp_t rsp_wdata, rsp_head;
    logic     req_full, req_empty, rsp_full, rsp_empty;
    logic [$clog2(REQ_DEPTH):0] req_count;
    logic [$clog2(RSP_DEPTH):0] rsp_count;

    div_state_e state_q, state_d;
    logic       issue, credit_ok, rsp_push, rsp_pop, timeout;

    assign req_wdata = '{op_a: req_op_a_i, op_b: req_op_b_i, rnd: req_rnd_i, tag: req_tag_i};
    assign rsp_wdata = '{res: div_res_i, status: div_status_i, tag: div_tag_i};

    fp_div_fifo #(.T(div_req_t), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_valid_i && !req_full),
        .data_i  (req_wdata),
        .pop_i   (issue),
        .data_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_count)
    );

    fp_div_fifo #(.T(div_rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_push),
        .data_i  (rsp_wdata),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    // The in-flight divide already owns a response slot, so count it against the FIFO.
    assign credit_ok = !rsp_full && ((32'(rsp_count) + 32'(state_q == BUSY)) < RSP_DEPTH);
    assign rsp_push  = (state_q == BUSY) && div_valid_i;
    assign rsp_pop   = resp_valid_o && resp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue = !req_empty && div_ready_i && credit_ok;
                if (issue) state_d = BUSY;
            end
            BUSY: begin
                if (div_valid_i) begin
                    issue   = !req_empty && div_ready_i && credit_ok;
                    state_d = issue ? BUSY : IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FP_DIV_ISSUE_WDOG_EN
    localparam int unsigned WD_W = $clog2(LATENCY + 3);
    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;

    // Counter holds k-1 in the k-th cycle after issue, so err_o rises LATENCY+2 cycles after div_en_o.
    assign timeout = (state_q == BUSY) && !div_valid_i && (wd_cnt_q == WD_W'(LATENCY));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (issue)                 wd_cnt_q <= '0;
            else if (state_q == BUSY)  wd_cnt_q <= wd_cnt_q + WD_W'(1);
            if (timeout)               err_q    <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign req_ready_o   = !req_full;
    assign div_en_o      = issue;
    assign div_op_a_o    = req_head.op_a;
    assign div_op_b_o    = req_head.op_b;
    assign div_rnd_o     = req_head.rnd;
    assign div_tag_o     = req_head.tag;
    assign resp_valid_o  = !rsp_empty;
    assign resp_res_o    = rsp_head.res;
    assign resp_status_o = rsp_head.status;
    assign resp_tag_o    = rsp_head.tag;

endmodule
